wb_cmd_master: RTL and testbench
================================

Name: wb_cmd_master

Overview:
- Synthesizable Wishbone classic initiator that turns a valid/ready command stream into single or incrementing-burst Wishbone cycles.
- Sits between a host-side agent (debug loader, DMA, program-loader UART) and the unified memory bus shared with custom_riscv_core.
- Lets the bench and the SoC preload or inspect memory without the core.
- Every beat is bounded by a timeout; errors and timeouts are returned as a status code.

Parameters:
- TIMEOUT_CYCLES, 255: cycles with stb high and no ack/err before the beat is aborted; legal range 1..65535.
- LEN_W, 8: width of the burst-length field; a burst is cmd_len+1 beats.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when valid&&ready
- cmd_addr  in  32  start byte address; bits [1:0] ignored
- cmd_we  in  1  1=write burst, 0=read burst
- cmd_sel  in  4  byte lanes, applied to every beat
- cmd_len  in  LEN_W  beats minus one
- wd_valid  in  1  write-data beat present
- wd_ready  out  1  write-data beat accepted
- wd_data  in  32  write-data beat
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_data  out  32  read data; 0 for writes
- rsp_status  out  2  00 OK, 01 bus error, 10 timeout
- rsp_last  out  1  final response of the command
- wb_adr_o  out  32  word-aligned address
- wb_dat_o  out  32  write data
- wb_dat_i  in  32  read data, valid in the ack cycle
- wb_we_o  out  1  write enable
- wb_sel_o  out  4  byte select
- wb_cyc_o  out  1  cycle
- wb_stb_o  out  1  strobe
- wb_ack_i  in  1  acknowledge
- wb_err_i  in  1  error
- busy  out  1  high whenever the FSM is not IDLE

Behaviour:
- Reset values (all asynchronous): cmd_ready=0, wd_ready=0, rsp_valid=0, rsp_data=0, rsp_status=0, rsp_last=0, wb_cyc_o=0, wb_stb_o=0, wb_we_o=0, wb_sel_o=0, wb_adr_o=0, wb_dat_o=0, busy=0.
- Reset mid-burst: cyc/stb drop immediately. No response is issued and the command is lost.
- States:
  - IDLE: cmd_ready=1. On cmd_valid, latch addr with [1:0] forced to 00, plus we/sel/len, and set beat counter=len. Go to WDATA if we, else to BUS.
  - WDATA: wd_ready=1. On wd_valid, latch wd_data into wb_dat_o and go to BUS.
  - BUS: cyc=stb=1; we/sel/adr are stable. The timeout counter clears on entry and increments each cycle.
    - ack (err=0): capture wb_dat_i when reading. Reads go to RESP. Writes go to RESP if this is the last beat, otherwise to NEXT.
    - err: status=01, last=1, go to RESP. ack and err in the same cycle count as err.
    - Counter reaches TIMEOUT_CYCLES with no ack/err: status=10, last=1, go to RESP.
  - RESP: rsp_valid=1 and fields are stable until rsp_ready.
    - After the handshake: if last, go to IDLE.
    - Otherwise NEXT: adr+=4 (wraps modulo 2^32), counter-=1, then go to WDATA or BUS.
  - NEXT (writes without a response): one cycle with cyc=stb=0.
- cyc/stb deassert in the cycle after ack is sampled, always for at least 1 idle cycle between beats. This is required by responders that ack only when !ack; a second ack can therefore never be consumed.
- Responses:
  - Reads: one response per beat; rsp_last=1 on the final beat.
  - Writes: one response only, on the last beat or on error/timeout, with rsp_data=0.
- Error and timeout abort the remaining beats. Unconsumed write data stays in the source; wd_ready is never raised again for that command.
- Latency: single read = command accept → stb in next cycle → rsp_valid the cycle after ack.
- A new command is accepted only in IDLE. Commands are never overlapped.

Decomposition:
- Shared package wb_pkg:
  - state encodings (IDLE/WDATA/BUS/RESP/NEXT)
  - rsp_status constants (WB_OK=2'b00, WB_BUSERR=2'b01, WB_TIMEOUT=2'b10)
- One natural sub-module: wb_timeout_ctr, a loadable saturating counter with clear, enable and expired outputs.

Test Plan:
- Single read: mem[0x40] = 32'hDEADBEEF; cmd addr 0x100, we=0, len=0 → one wb read at adr 0x100; rsp_data = DEADBEEF, status 00, last=1.
- Write burst: addr 0x200, len=3, sel=F, data 1, 2, 3, 4 → adr 0x200/204/208/20C; cyc low ≥1 cycle between beats; single response, status 00, last=1; memory holds 1..4.
- Byte lanes with misalignment: addr 0x303, sel=4'b0010, data 32'h0000AB00 → adr 0x300; only byte 1 changes; readback 0x0000AB13 from NOP init 0x00000013.
- Error abort: responder raises err on beat 2 of a len=3 read → responses for beats 0 and 1 with status 00, last=0; then status 01, last=1; no further stb.
- Timeout: TIMEOUT_CYCLES=16, responder never acks → stb high for exactly 16 cycles; status 10, last=1; busy returns to 0.
- Backpressure and reset: hold rsp_ready=0 for 10 cycles during a len=1 read → rsp fields stable and no new stb issued. Then assert rst_n=0 mid-BUS → cyc/stb drop in the same cycle.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared encodings for the Wishbone command master: FSM states, response
// status codes and an address helper.
package wb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WDATA,
    ST_BUS,
    ST_RESP,
    ST_NEXT
  } wb_state_e;

  localparam logic [1:0] WB_OK      = 2'b00;
  localparam logic [1:0] WB_BUSERR  = 2'b01;
  localparam logic [1:0] WB_TIMEOUT = 2'b10;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/wb_timeout_ctr.sv
// Loadable saturating cycle counter; expired flags the LIMIT-th counted cycle
// so the owner can abort on that same edge.
module wb_timeout_ctr #(
  parameter int unsigned LIMIT = 255,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expired
);

  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (load)
      cnt_d = load_val;
    else if (en && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign expired = (cnt_q >= LIMIT_M1);

endmodule

// File: rtl/wb_cmd_master.sv
// Wishbone classic initiator: converts valid/ready commands into single or
// incrementing-burst bus cycles with per-beat timeout and status responses.
module wb_cmd_master
  import wb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned LEN_W          = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_addr,
  input  logic             cmd_we,
  input  logic [3:0]       cmd_sel,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             wd_valid,
  output logic             wd_ready,
  input  logic [31:0]      wd_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic [1:0]       rsp_status,
  output logic             rsp_last,
  output logic [31:0]      wb_adr_o,
  output logic [31:0]      wb_dat_o,
  input  logic [31:0]      wb_dat_i,
  output logic             wb_we_o,
  output logic [3:0]       wb_sel_o,
  output logic             wb_cyc_o,
  output logic             wb_stb_o,
  input  logic             wb_ack_i,
  input  logic             wb_err_i,
  output logic             busy
);

  wb_state_e        state_q, state_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             wd_ready_q, wd_ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_data_q, rsp_data_d;
  logic [1:0]       rsp_status_q, rsp_status_d;
  logic             rsp_last_q, rsp_last_d;
  logic             stb_q, stb_d;
  logic             we_q, we_d;
  logic [3:0]       sel_q, sel_d;
  logic [31:0]      adr_q, adr_d;
  logic [31:0]      dat_q, dat_d;
  logic [LEN_W-1:0] beat_q, beat_d;
  logic             busy_q, busy_d;
  logic             tmo_clr, tmo_expired;

  wb_timeout_ctr #(
    .LIMIT (TIMEOUT_CYCLES),
    .CNT_W (16)
  ) u_tmo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (tmo_clr),
    .en       (state_q == ST_BUS),
    .load     (1'b0),
    .load_val (16'd0),
    .expired  (tmo_expired)
  );

  always_comb begin
    state_d      = state_q;
    cmd_ready_d  = cmd_ready_q;
    wd_ready_d   = wd_ready_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    rsp_status_d = rsp_status_q;
    rsp_last_d   = rsp_last_q;
    stb_d        = stb_q;
    we_d         = we_q;
    sel_d        = sel_q;
    adr_d        = adr_q;
    dat_d        = dat_q;
    beat_d       = beat_q;
    tmo_clr      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          adr_d       = word_align(cmd_addr);
          we_d        = cmd_we;
          sel_d       = cmd_sel;
          beat_d      = cmd_len;
          if (cmd_we) begin
            state_d    = ST_WDATA;
            wd_ready_d = 1'b1;
          end else begin
            state_d = ST_BUS;
            stb_d   = 1'b1;
            tmo_clr = 1'b1;
          end
        end
      end

      ST_WDATA: begin
        if (wd_valid && wd_ready_q) begin
          dat_d      = wd_data;
          wd_ready_d = 1'b0;
          state_d    = ST_BUS;
          stb_d      = 1'b1;
          tmo_clr    = 1'b1;
        end
      end

      ST_BUS: begin
        // err wins over a simultaneous ack; both end the strobe on this edge
        if (wb_err_i) begin
          stb_d        = 1'b0;
          rsp_valid_d  = 1'b1;
          rsp_data_d   = '0;
          rsp_status_d = WB_BUSERR;
          rsp_last_d   = 1'b1;
          state_d      = ST_RESP;
        end else if (wb_ack_i) begin
          stb_d = 1'b0;
          if (!we_q) begin
            rsp_valid_d  = 1'b1;
            rsp_data_d   = wb_dat_i;
            rsp_status_d = WB_OK;
            rsp_last_d   = (beat_q == '0);
            state_d      = ST_RESP;
          end else if (beat_q == '0) begin
            rsp_valid_d  = 1'b1;
            rsp_data_d   = '0;
            rsp_status_d = WB_OK;
            rsp_last_d   = 1'b1;
            state_d      = ST_RESP;
          end else begin
            state_d = ST_NEXT;
          end
        end else if (tmo_expired) begin
          stb_d        = 1'b0;
          rsp_valid_d  = 1'b1;
          rsp_data_d   = '0;
          rsp_status_d = WB_TIMEOUT;
          rsp_last_d   = 1'b1;
          state_d      = ST_RESP;
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (rsp_last_q) begin
            state_d     = ST_IDLE;
            cmd_ready_d = 1'b1;
          end else begin
            // only read bursts reach here mid-command; the RESP cycle is the idle gap
            adr_d   = adr_q + 32'd4;
            beat_d  = beat_q - LEN_W'(1);
            state_d = ST_BUS;
            stb_d   = 1'b1;
            tmo_clr = 1'b1;
          end
        end
      end

      ST_NEXT: begin
        adr_d      = adr_q + 32'd4;
        beat_d     = beat_q - LEN_W'(1);
        state_d    = ST_WDATA;
        wd_ready_d = 1'b1;
      end

      default: begin
        state_d = ST_IDLE;
        stb_d   = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cmd_ready_q  <= 1'b0;
      wd_ready_q   <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_status_q <= WB_OK;
      rsp_last_q   <= 1'b0;
      stb_q        <= 1'b0;
      we_q         <= 1'b0;
      sel_q        <= '0;
      adr_q        <= '0;
      dat_q        <= '0;
      beat_q       <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_ready_q  <= cmd_ready_d;
      wd_ready_q   <= wd_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_status_q <= rsp_status_d;
      rsp_last_q   <= rsp_last_d;
      stb_q        <= stb_d;
      we_q         <= we_d;
      sel_q        <= sel_d;
      adr_q        <= adr_d;
      dat_q        <= dat_d;
      beat_q       <= beat_d;
      busy_q       <= busy_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign wd_ready   = wd_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_status = rsp_status_q;
  assign rsp_last   = rsp_last_q;
  assign wb_adr_o   = adr_q;
  assign wb_dat_o   = dat_q;
  assign wb_we_o    = we_q;
  assign wb_sel_o   = sel_q;
  assign wb_cyc_o   = stb_q;
  assign wb_stb_o   = stb_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Self-checking bench for wb_cmd_master: Wishbone memory responder plus a
// word/byte-lane reference model of the expected responses and bus addresses.
module tb_wb_cmd_master;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [31:0] cmd_addr = '0;
  logic        cmd_we = 1'b0;
  logic [3:0]  cmd_sel = '0;
  logic [7:0]  cmd_len = '0;
  logic        wd_valid = 1'b0, wd_ready;
  logic [31:0] wd_data = '0;
  logic        rsp_valid, rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_status;
  logic        rsp_last;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i = '0;
  logic        wb_we_o, wb_cyc_o, wb_stb_o, busy;
  logic [3:0]  wb_sel_o;
  logic        wb_ack_i = 1'b0, wb_err_i = 1'b0;

  wb_cmd_master #(.TIMEOUT_CYCLES(TMO), .LEN_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_we(cmd_we), .cmd_sel(cmd_sel), .cmd_len(cmd_len),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_status(rsp_status), .rsp_last(rsp_last),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o), .wb_cyc_o(wb_cyc_o),
    .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem   [0:1023];
  logic [31:0] model [0:1023];
  logic [31:0] wbuf  [0:15];

  bit  noack = 1'b0;
  int  err_at = -1;
  int  beat_idx = 0;
  int  max_dly = 0;
  int  wait_cnt = 0;
  int  stb_cnt = 0;
  int  viol = 0;
  int  overlap = 0;
  int  unstable = 0;
  logic [31:0] adr_log [$];
  logic [31:0] r_data [$];
  logic [1:0]  r_stat [$];
  logic        r_last [$];

  // Memory responder: acks only while !ack, after a random wait
  always @(negedge clk) begin
    if (wb_stb_o) stb_cnt++;
    if (rsp_valid && wb_stb_o) overlap++;
    if (!rst_n) begin
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      wait_cnt = 0;
    end else if (wb_ack_i || wb_err_i) begin
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      if (wb_stb_o) viol++;
    end else if (wb_cyc_o && wb_stb_o && !noack) begin
      if (wait_cnt > 0) begin
        wait_cnt--;
      end else begin
        adr_log.push_back(wb_adr_o);
        if (beat_idx == err_at) begin
          wb_err_i = 1'b1;
        end else begin
          wb_ack_i = 1'b1;
          if (wb_we_o) begin
            for (int b = 0; b < 4; b++)
              if (wb_sel_o[b]) mem[wb_adr_o[11:2]][8*b +: 8] = wb_dat_o[8*b +: 8];
          end else begin
            wb_dat_i = mem[wb_adr_o[11:2]];
          end
        end
        beat_idx++;
        wait_cnt = $urandom_range(0, max_dly);
      end
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_cmd(input logic [31:0] a, input logic we, input logic [3:0] sel,
                         input int len, input int hold);
    int n = 0;
    int wi = 0;
    int held = 0;
    int h = hold;
    bit done = 1'b0;
    logic [34:0] snap = '0;
    r_data.delete(); r_stat.delete(); r_last.delete(); adr_log.delete();
    beat_idx = 0;
    wait_cnt = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_addr = a; cmd_we = we; cmd_sel = sel; cmd_len = 8'(len);
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      cmd_valid = 1'b0;
      checks++; errors++;
      $error("FAIL cmd_accept: observed no cmd_ready within 200 cycles, required ready");
      return;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (!done && n < 2000) begin
      wd_valid = 1'b0;
      rsp_ready = 1'b0;
      if (wd_ready && wi <= len) begin
        wd_valid = 1'b1;
        wd_data = wbuf[wi];
        wi++;
      end
      if (rsp_valid) begin
        if (held < h) begin
          if (held == 0) snap = {rsp_data, rsp_status, rsp_last};
          else if (snap !== {rsp_data, rsp_status, rsp_last}) unstable++;
          held++;
        end else begin
          rsp_ready = 1'b1;
          r_data.push_back(rsp_data);
          r_stat.push_back(rsp_status);
          r_last.push_back(rsp_last);
          if (rsp_last) done = 1'b1;
          held = 0;
          h = 0;
        end
      end
      @(negedge clk);
      n++;
    end
    rsp_ready = 1'b0;
    wd_valid = 1'b0;
    if (!done) begin
      checks++; errors++;
      $error("FAIL cmd_done: observed no last response within 2000 cycles, required last");
    end
  endtask

  // Reference: beats proceed word by word from the aligned address until an
  // error/timeout; writes merge enabled byte lanes into the model memory.
  task automatic expect_cmd(input string tag, input logic [31:0] a, input logic we,
                            input logic [3:0] sel, input int len, input int eat, input bit tmo);
    logic [31:0] base = a & 32'hFFFF_FFFC;
    bit   abort_err = (eat >= 0 && eat <= len);
    int   good = tmo ? 0 : (abort_err ? eat : len + 1);
    logic [1:0] fst = tmo ? 2'b10 : (abort_err ? 2'b01 : 2'b00);
    int   logged = tmo ? 0 : (abort_err ? good + 1 : good);
    int   nr;
    chk({tag, "_nbeats"}, 128'(adr_log.size()), 128'(logged));
    for (int i = 0; i < logged && i < adr_log.size(); i++)
      chk({tag, "_adr"}, adr_log[i], base + 32'(4 * i));
    if (we) begin
      for (int i = 0; i < good; i++)
        for (int b = 0; b < 4; b++)
          if (sel[b]) model[(base[11:2] + 10'(i))][8*b +: 8] = wbuf[i][8*b +: 8];
      nr = 1;
    end else begin
      nr = good + ((fst != 2'b00) ? 1 : 0);
    end
    chk({tag, "_nrsp"}, 128'(r_data.size()), 128'(nr));
    if (r_data.size() != nr) return;
    if (we) begin
      chk({tag, "_wdata"}, r_data[0], 32'h0);
      chk({tag, "_wstat"}, r_stat[0], fst);
      chk({tag, "_wlast"}, r_last[0], 1'b1);
    end else begin
      for (int i = 0; i < good; i++) begin
        chk({tag, "_rdata"}, r_data[i], model[(base[11:2] + 10'(i))]);
        chk({tag, "_rstat"}, r_stat[i], 2'b00);
        chk({tag, "_rlast"}, r_last[i], 1'(i == len));
      end
      if (fst != 2'b00) begin
        chk({tag, "_astat"}, r_stat[good], fst);
        chk({tag, "_alast"}, r_last[good], 1'b1);
      end
    end
  endtask

  initial begin
    logic [31:0] a;
    logic        we;
    logic [3:0]  sel;
    int          len, hold, s0;

    for (int i = 0; i < 1024; i++) begin
      mem[i] = 32'h0000_0013;
      model[i] = 32'h0000_0013;
    end
    mem[10'h40] = 32'hDEAD_BEEF;
    model[10'h40] = 32'hDEAD_BEEF;

    #12;
    chk("reset_outputs",
        {cmd_ready, wd_ready, rsp_valid, rsp_data, rsp_status, rsp_last, wb_cyc_o,
         wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o, busy}, 128'h0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single read
    run_cmd(32'h100, 1'b0, 4'hF, 0, 0);
    expect_cmd("single_rd", 32'h100, 1'b0, 4'hF, 0, -1, 1'b0);
    if (r_data.size() > 0) chk("single_rd_const", r_data[0], 32'hDEAD_BEEF);

    // Write burst followed by readback
    for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
    max_dly = 2;
    run_cmd(32'h200, 1'b1, 4'hF, 3, 0);
    expect_cmd("wr_burst", 32'h200, 1'b1, 4'hF, 3, -1, 1'b0);
    run_cmd(32'h200, 1'b0, 4'hF, 3, 0);
    expect_cmd("wr_readback", 32'h200, 1'b0, 4'hF, 3, -1, 1'b0);
    if (r_data.size() == 4) chk("wr_readback_b3", r_data[3], 32'h4);

    // Misaligned single byte lane
    wbuf[0] = 32'h0000_AB00;
    run_cmd(32'h303, 1'b1, 4'b0010, 0, 0);
    expect_cmd("lane_wr", 32'h303, 1'b1, 4'b0010, 0, -1, 1'b0);
    run_cmd(32'h300, 1'b0, 4'hF, 0, 0);
    expect_cmd("lane_rd", 32'h300, 1'b0, 4'hF, 0, -1, 1'b0);
    if (r_data.size() > 0) chk("lane_rd_const", r_data[0], 32'h0000_AB13);

    // Bus error on beat 2 of a 4-beat read
    max_dly = 0;
    err_at = 2;
    run_cmd(32'h800, 1'b0, 4'hF, 3, 0);
    err_at = -1;
    expect_cmd("err_rd", 32'h800, 1'b0, 4'hF, 3, 2, 1'b0);
    s0 = stb_cnt;
    repeat (5) @(negedge clk);
    chk("err_no_more_stb", 128'(stb_cnt), 128'(s0));

    // Error during a write burst leaves remaining data unconsumed
    for (int i = 0; i < 3; i++) wbuf[i] = $urandom;
    err_at = 1;
    run_cmd(32'h840, 1'b1, 4'hF, 2, 0);
    err_at = -1;
    expect_cmd("err_wr", 32'h840, 1'b1, 4'hF, 2, 1, 1'b0);
    repeat (3) @(negedge clk);
    chk("err_wr_wd_ready", wd_ready, 1'b0);

    // Timeout: no ack ever
    noack = 1'b1;
    stb_cnt = 0;
    run_cmd(32'h500, 1'b0, 4'hF, 2, 0);
    chk("tmo_stb_cycles", 128'(stb_cnt), 128'(TMO));
    expect_cmd("tmo", 32'h500, 1'b0, 4'hF, 2, -1, 1'b1);
    chk("tmo_busy", busy, 1'b0);
    noack = 1'b0;

    // Backpressure on the first response of a 2-beat read
    overlap = 0;
    unstable = 0;
    run_cmd(32'h700, 1'b0, 4'hF, 1, 10);
    expect_cmd("bp_rd", 32'h700, 1'b0, 4'hF, 1, -1, 1'b0);
    chk("bp_stable", 128'(unstable), 128'(0));
    chk("bp_no_stb", 128'(overlap), 128'(0));

    // Randomized commands against the model
    for (int k = 0; k < 14; k++) begin
      a = 32'($urandom_range(0, 32'hF00));
      we = 1'($urandom_range(0, 1));
      sel = 4'($urandom_range(1, 15));
      len = $urandom_range(0, 5);
      hold = $urandom_range(0, 3);
      max_dly = $urandom_range(0, 3);
      for (int i = 0; i < 16; i++) wbuf[i] = $urandom;
      run_cmd(a, we, sel, len, hold);
      expect_cmd("rand", a, we, sel, len, -1, 1'b0);
    end
    max_dly = 0;

    // Reset in the middle of a bus beat
    noack = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_addr = 32'h600; cmd_we = 1'b0; cmd_sel = 4'hF; cmd_len = 8'd1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("rst_pre_stb", wb_stb_o, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_cyc_stb", {wb_cyc_o, wb_stb_o}, 2'b00);
    chk("rst_outputs",
        {cmd_ready, wd_ready, rsp_valid, rsp_data, rsp_status, rsp_last,
         wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o, busy}, 128'h0);
    noack = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_no_rsp", rsp_valid, 1'b0);
    chk("rst_idle_ready", {cmd_ready, busy}, 2'b10);

    chk("ack_gap_violations", 128'(viol), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
